// File: rtl/alu_sequencer_if.sv
// Requester, ALU and response bundle for the ALU sequencer.
// Latency: none; this interface holds wires only.
// Backpressure: req_ready / rsp_ready give valid/ready flow control on both ends.
interface alu_sequencer_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  // shared ALU connection
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_wide;
  logic        rsp_error;

  // sequencer side
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_c, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode,
           rsp_valid, rsp_hi, rsp_lo, rsp_wide, rsp_error
  );

  // requester / ALU side
  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_c, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode,
           rsp_valid, rsp_hi, rsp_lo, rsp_wide, rsp_error
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through the shared ALU and returns the 64-bit result.
// Latency: LAT(op)+1 edges counting the accept edge for legal ops, 1 edge for errors.
// Backpressure: no request is accepted until the response handshake completes.
module alu_sequencer #(
  parameter int unsigned BASE_LAT = 1,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 4
) (
  input  logic           clock,
  input  logic           clear,
  alu_sequencer_if.slave bus,
  output logic           busy,
  output logic [15:0]    op_count
);

  localparam logic [4:0] OP_FIRST = 5'b00011;  // Add
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_LAST  = 5'b10010;  // NOT

  localparam int unsigned MAX_LAT =
      (BASE_LAT > MUL_LAT) ? ((BASE_LAT > DIV_LAT) ? BASE_LAT : DIV_LAT)
                           : ((MUL_LAT  > DIV_LAT) ? MUL_LAT  : DIV_LAT);
  // counter holds LAT-1 at most
  localparam int unsigned CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       y_q, y_d;
  logic [31:0]       b_q, b_d;
  logic [4:0]        op_q, op_d;
  logic [63:0]       z_q, z_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              req_legal;
  logic              req_div0;

  // Settling cycles minus one, so the counter reaching zero marks the capture cycle.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [4:0] op);
    if (op == OP_MUL) begin
      return CNT_W'(MUL_LAT - 1);
    end else if (op == OP_DIV) begin
      return CNT_W'(DIV_LAT - 1);
    end else begin
      return CNT_W'(BASE_LAT - 1);
    end
  endfunction

  // Classify the incoming request: opcode range check and divide-by-zero.
  always_comb begin
    req_legal = (bus.req_opcode >= OP_FIRST) && (bus.req_opcode <= OP_LAST);
    req_div0  = (bus.req_opcode == OP_DIV) && (bus.req_b == 32'd0);
  end

  // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    b_d        = b_q;
    op_d       = op_q;
    z_d        = z_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    op_count_d = op_count_q;

    case (state_q)
      IDLE: begin
        // req_ready is just IDLE while out of reset, so valid alone completes the handshake
        if (bus.req_valid) begin
          y_d  = bus.req_a;
          b_d  = bus.req_b;
          op_d = bus.req_opcode;
          if (req_legal && !req_div0) begin
            cnt_d   = lat_m1(bus.req_opcode);
            state_d = EXEC;
          end else begin
            // error responses skip the ALU entirely
            z_d     = 64'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      EXEC: begin
        // operands stay on the ALU until the settling count runs out
        if (cnt_q == '0) begin
          z_d     = bus.alu_c;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      y_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 5'd0;
      z_q        <= 64'd0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      b_q        <= b_d;
      op_q       <= op_d;
      z_q        <= z_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
    end
  end

  // Output decode: the ALU sees the registered operands, the response shows Z.
  always_comb begin
    bus.req_ready  = (state_q == IDLE) && clear;
    bus.alu_a      = y_q;
    bus.alu_b      = b_q;
    bus.alu_opcode = op_q;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_hi     = z_q[63:32];
    bus.rsp_lo     = z_q[31:0];
    bus.rsp_wide   = (state_q == RESP) && ((op_q == OP_MUL) || (op_q == OP_DIV));
    bus.rsp_error  = err_q;
    busy           = (state_q != IDLE);
    op_count       = op_count_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed literal cases plus randomized traffic vs a cycle model.
// Latency: the model predicts the response edge from the settling-latency rules.
// Backpressure: rsp_ready is held low and randomized to exercise stalls.
module tb_alu_sequencer;
  localparam int unsigned BASE_LAT = 1;
  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned DIV_LAT  = 4;

  logic        clock;
  logic        clear;
  logic        busy;
  logic [15:0] op_count;
  int          tests = 0;
  int          fails = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(
    .BASE_LAT (BASE_LAT),
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in ALU: Add=3, Sub=4 (bench choice), Div=15 {quot,rem}, Mul=16 full product.
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      5'd3:    return {32'd0, a + b};
      5'd4:    return {32'd0, a - b};
      5'd15:   return (b == 32'd0) ? 64'd0 : {a / b, a % b};
      5'd16:   return {32'd0, a} * {32'd0, b};
      default: begin
        r = (a ^ b) + {27'd0, op};
        return {32'd0, r};
      end
    endcase
  endfunction

  always_comb bus.alu_c = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);

  function automatic int lat_of(input logic [4:0] op);
    if (op == 5'd16) return int'(MUL_LAT);
    if (op == 5'd15) return int'(DIV_LAT);
    return int'(BASE_LAT);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: phase 0 idle, 1 computing, 2 responding
  int          ph;
  int          mwait;
  logic [31:0] ma, mb;
  logic [4:0]  mop;
  logic [63:0] mres;
  logic        merr;
  logic [15:0] mcnt;

  // Check the DUT against the model each cycle, then step the model with the inputs
  // that the next rising edge will sample.
  always @(negedge clock) begin
    if (!clear) begin
      ph = 0; mwait = 0; ma = '0; mb = '0; mop = '0; mres = '0; merr = 1'b0; mcnt = '0;
    end
    chk("req_ready", bus.req_ready, clear && (ph == 0));
    chk("busy", busy, ph != 0);
    chk("rsp_valid", bus.rsp_valid, ph == 2);
    chk("alu_a", bus.alu_a, ma);
    chk("alu_b", bus.alu_b, mb);
    chk("alu_opcode", bus.alu_opcode, mop);
    chk("op_count", op_count, mcnt);
    if (ph == 2) begin
      chk("rsp_hi", bus.rsp_hi, mres[63:32]);
      chk("rsp_lo", bus.rsp_lo, mres[31:0]);
      chk("rsp_wide", bus.rsp_wide, (mop == 5'd15) || (mop == 5'd16));
      chk("rsp_error", bus.rsp_error, merr);
    end else begin
      chk("rsp_wide_idle", bus.rsp_wide, 1'b0);
    end
    if (clear) begin
      case (ph)
        0: if (bus.req_valid) begin
          ma = bus.req_a; mb = bus.req_b; mop = bus.req_opcode;
          if (mop >= 5'd3 && mop <= 5'd18 && !(mop == 5'd15 && mb == 32'd0)) begin
            ph = 1; mwait = lat_of(mop);
          end else begin
            ph = 2; mres = 64'd0; merr = 1'b1;
          end
        end
        1: begin
          mwait--;
          if (mwait == 0) begin
            ph = 2; mres = alu_ref(mop, ma, mb); merr = 1'b0;
          end
        end
        default: if (bus.rsp_ready) begin
          mcnt = mcnt + 16'd1; ph = 0;
        end
      endcase
    end
  end

  // ---------------- directed helpers (entered and left at posedge+2)
  task automatic wait_rsp(input logic [31:0] a, input logic [31:0] b, output int n);
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clock); #2;
      n++;
      chk("alu_a_stable", bus.alu_a, a);
      chk("alu_b_stable", bus.alu_b, b);
    end
  endtask

  task automatic do_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int edges, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic ewide, input logic eerr,
                       input int hold);
    int n;
    chk({nm, "_ready_before"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_a = a; bus.req_b = b;
    @(posedge clock); #2;
    bus.req_valid = 1'b0;
    wait_rsp(a, b, n);
    chk({nm, "_latency"}, n, edges);
    chk({nm, "_hi"}, bus.rsp_hi, ehi);
    chk({nm, "_lo"}, bus.rsp_lo, elo);
    chk({nm, "_wide"}, bus.rsp_wide, ewide);
    chk({nm, "_error"}, bus.rsp_error, eerr);
    repeat (hold) begin
      @(posedge clock); #2;
      chk({nm, "_hold_valid"}, bus.rsp_valid, 1'b1);
      chk({nm, "_hold_ready"}, bus.req_ready, 1'b0);
      chk({nm, "_hold_lo"}, bus.rsp_lo, elo);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #2;
    bus.rsp_ready = 1'b0;
    chk({nm, "_valid_drop"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear = 1'b0;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("reset_req_ready", bus.req_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_op_count", op_count, 16'd0);
    repeat (3) @(posedge clock);
    #2 clear = 1'b1;
    @(posedge clock); #2;

    do_op("add", 5'd3, 32'd5, 32'd7, 2, 32'd0, 32'd12, 1'b0, 1'b0, 0);
    chk("add_op_count", op_count, 16'd1);
    do_op("mul", 5'd16, 32'h0001_0000, 32'h0001_0000, 3, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    do_op("div", 5'd15, 32'd17, 32'd5, 5, 32'd3, 32'd2, 1'b1, 1'b0, 0);
    do_op("div0", 5'd15, 32'd17, 32'd0, 1, 32'd0, 32'd0, 1'b1, 1'b1, 2);
    do_op("ill0", 5'd0, 32'd9, 32'd9, 1, 32'd0, 32'd0, 1'b0, 1'b1, 3);
    do_op("ill31", 5'd31, 32'd9, 32'd9, 1, 32'd0, 32'd0, 1'b0, 1'b1, 3);

    // backpressure: Sub 9-4 stalled 5 cycles while a second request waits
    bus.req_valid = 1'b1; bus.req_opcode = 5'd4; bus.req_a = 32'd9; bus.req_b = 32'd4;
    @(posedge clock); #2;
    bus.req_opcode = 5'd3; bus.req_a = 32'd2; bus.req_b = 32'd3;
    wait_rsp(32'd9, 32'd4, n);
    chk("sub_latency", n, 2);
    repeat (5) begin
      @(posedge clock); #2;
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_lo", bus.rsp_lo, 32'd5);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_alu_a", bus.alu_a, 32'd9);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #2;
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", bus.req_ready, 1'b1);
    @(posedge clock); #2;
    bus.req_valid = 1'b0;
    chk("bp_second_accepted", busy, 1'b1);
    wait_rsp(32'd2, 32'd3, n);
    chk("bp_second_lo", bus.rsp_lo, 32'd5);
    bus.rsp_ready = 1'b1;
    @(posedge clock); #2;
    bus.rsp_ready = 1'b0;
    chk("bp_op_count", op_count, 16'd8);

    // reset in the second cycle of a divide
    bus.req_valid = 1'b1; bus.req_opcode = 5'd15; bus.req_a = 32'd17; bus.req_b = 32'd5;
    @(posedge clock); #2;
    bus.req_valid = 1'b0;
    @(posedge clock); #2;
    clear = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_op", bus.alu_opcode, 5'd0);
    chk("rst_z", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    chk("rst_op_count", op_count, 16'd0);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #2;
    do_op("add11", 5'd3, 32'd1, 32'd1, 2, 32'd0, 32'd2, 1'b0, 1'b0, 0);
    chk("add11_op_count", op_count, 16'd1);

    // randomized traffic, checked every cycle by the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r;
      r = int'($urandom_range(0, 9));
      bus.req_valid = ($urandom_range(0, 2) != 0);
      if (r < 2)      bus.req_opcode = 5'($urandom_range(0, 31));
      else if (r < 4) bus.req_opcode = 5'd15;
      else if (r < 6) bus.req_opcode = 5'd16;
      else            bus.req_opcode = 5'($urandom_range(3, 18));
      bus.req_a = $urandom;
      bus.req_b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) clear = 1'b0;
      @(posedge clock); #2;
      clear = 1'b1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the shared 64-bit-result ALU on behalf of one requester. It accepts an operation (opcode, A, B) over a valid/ready handshake and loads A into the Y register. It drives B and the opcode to the ALU, holds the operands stable for a per-opcode settling latency, then captures the ALU result into the 64-bit Z register. The result is returned over a second valid/ready handshake, with divide-by-zero and illegal-opcode detection.

Parameters:
BASE_LAT, 1, settling cycles for add/sub/logic/shift/rotate/immediate/neg/not ops (min 1)
MUL_LAT, 2, settling cycles for Multiply (min 1)
DIV_LAT, 4, settling cycles for Divide (min 1)

Ports:
clock  in  1  system clock, rising-edge
clear  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_opcode  in  5  ALU opcode (same encoding as ALU: Add=00011 ... NOT=10010)
req_a  in  32  operand A (loaded into Y)
req_b  in  32  operand B
alu_a  out  32  Y register, to ALU input A
alu_b  out  32  registered B, to ALU input B
alu_opcode  out  5  registered opcode, to ALU
alu_c  in  64  ALU result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_hi  out  32  Z[63:32]
rsp_lo  out  32  Z[31:0]
rsp_wide  out  1  1 for Multiply/Divide (hi meaningful)
rsp_error  out  1  illegal opcode or divide by zero
busy  out  1  state != IDLE
op_count  out  16  completed responses (handshakes), wraps 0xFFFF->0

Behaviour:
- clear low (async): state=IDLE; Y, B, opcode, Z, cnt, op_count = 0; rsp_valid=0, rsp_error=0, rsp_wide=0, busy=0; req_ready=0 while clear low.
- States: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) and clear high. No accept in EXEC/RESP. No overlap between operations.
- IDLE, req_valid&req_ready at edge: Y<=req_a, B<=req_b, opcode<=req_opcode; classify:
  - legal opcode (00011..10010) and not (Divide with req_b==0): cnt<=LAT(op)-1, state<=EXEC.
  - illegal opcode, or Divide with req_b==0: Z<=0, rsp_error<=1, state<=RESP. No EXEC cycles.
- LAT(op): MUL_LAT for 10000, DIV_LAT for 01111, BASE_LAT otherwise.
- EXEC: alu_a/alu_b/alu_opcode held stable. If cnt==0: Z<=alu_c, rsp_error<=0, state<=RESP. Else cnt<=cnt-1.
- Latency from accept edge to rsp_valid high: LAT+1 edges for legal ops, 1 edge for error.
- RESP: rsp_valid=1; rsp_hi/rsp_lo/rsp_wide/rsp_error held stable until handshake. On rsp_ready: op_count<=op_count+1, state<=IDLE. rsp_valid drops on the next cycle. Next accept is at the earliest on the cycle after.
- rsp_wide = registered opcode is 10000 or 01111, in RESP only (0 elsewhere).
- Divide result layout: hi=quotient, lo=remainder. Multiply: full 64-bit product. Others: hi=0 from ALU.
- alu_* outputs remain at last values in IDLE (no spurious changes). Z is not cleared between ops.
- Reset mid-EXEC/RESP: immediate return to IDLE, all registers zero, pending result discarded, op_count not incremented.
- rsp_ready high outside RESP: ignored. req_valid dropping before acceptance: no effect.

Test Plan:
- Add: A=5, B=7, opcode 00011, rsp_ready=1 -> rsp_valid 2 edges after accept, lo=12, hi=0, wide=0, error=0, op_count=1.
- Multiply: A=0x0001_0000, B=0x0001_0000, MUL_LAT=2 -> rsp_valid 3 edges after accept, hi=1, lo=0, wide=1. alu_a/alu_b stable across EXEC.
- Divide: A=17, B=5, DIV_LAT=4 -> rsp_valid 5 edges after accept, hi=3, lo=2, wide=1. Then A=17, B=0 -> rsp_valid 1 edge after accept, error=1, hi=lo=0.
- Illegal opcode 00000 and 11111 -> error=1 after 1 edge, hi=lo=0, req_ready low until handshake.
- Backpressure: Sub 9-4 with rsp_ready low 5 cycles -> rsp_valid and lo=5 held, req_ready=0, a second req_valid is not accepted. It is accepted only after rsp_ready pulses and the FSM returns to IDLE.
- Reset mid-EXEC of Divide (cycle 2) -> outputs zero asynchronously, busy=0, op_count unchanged (0). A fresh Add 1+1 afterwards returns 2.
